// File: rtl/clk_stabilizer_gf.sv
// clk_stabilizer_gf: glitch-free break-before-make 2:1 clock switch.
// All control runs on stable_clk; prog_clk is only ever gated, never clocks a flop.
module clk_stabilizer_gf #(
   parameter int SYNC_STAGES = 2,
   parameter int DEAD_CYCLES = 2
) (
   input  logic stable_clk,
   input  logic resetn,
   input  logic clk_select,
   input  logic prog_clk,
   output logic out_clk
);

   localparam int CW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEAD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_STABLE,
      ST_PROG,
      ST_DRAIN
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   en_s_q, en_s_d;
   logic                   en_p_q, en_p_d;
   logic                   tgt_q, tgt_d;
   logic                   sel_s;
   logic                   en_s_lat;
   logic                   en_p_lat;

   assign sel_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], clk_select};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      en_s_d  = en_s_q;
      en_p_d  = en_p_q;
      tgt_d   = tgt_q;
      unique case (state_q)
         ST_STABLE: begin
            en_s_d = 1'b1;
            en_p_d = 1'b0;
            if (sel_s != tgt_q) begin
               state_d = ST_DRAIN;
               en_s_d  = 1'b0;
               cnt_d   = '0;
            end
         end
         ST_PROG: begin
            en_s_d = 1'b0;
            en_p_d = 1'b1;
            if (sel_s != tgt_q) begin
               state_d = ST_DRAIN;
               en_p_d  = 1'b0;
               cnt_d   = '0;
            end
         end
         ST_DRAIN: begin
            en_s_d = 1'b0;
            en_p_d = 1'b0;
            // Source is chosen only now, so a request that reverted mid-drain
            // lands back on the original clock without touching the other one.
            if (cnt_q == CNT_LAST) begin
               tgt_d   = sel_s;
               cnt_d   = '0;
               state_d = sel_s ? ST_PROG : ST_STABLE;
               en_s_d  = ~sel_s;
               en_p_d  = sel_s;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_DRAIN;
            en_s_d  = 1'b0;
            en_p_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge stable_clk) begin
      if (!resetn) begin
         state_q <= ST_DRAIN;
         sync_q  <= '0;
         cnt_q   <= '0;
         en_s_q  <= 1'b0;
         en_p_q  <= 1'b0;
         tgt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         en_s_q  <= en_s_d;
         en_p_q  <= en_p_d;
         tgt_q   <= tgt_d;
      end
   end

   // ICG-style gates: each enable may only move while its own clock is low.
   always_latch begin
      if (!stable_clk) en_s_lat <= en_s_q;
   end

   always_latch begin
      if (!prog_clk) en_p_lat <= en_p_q;
   end

   assign out_clk = (stable_clk & en_s_lat) | (prog_clk & en_p_lat);

   a_one_hot_en: assert property (
      @(posedge stable_clk) !(en_s_q && en_p_q)
   );

endmodule

// File: tb/tb_clk_stabilizer_gf.sv
// tb_clk_stabilizer_gf: scoreboard bench for the glitch-free clock switch.
// Windows classify out_clk by rising-edge count: 1=stable, 3=prog, 0=idle.
`timescale 1ps/1ps
module tb_clk_stabilizer_gf;

   localparam int WIN     = 600;
   localparam int N_STAB  = 1;
   localparam int N_PROG  = 3;
   localparam int N_IDLE  = 0;
   localparam int MIN_GAP = 900;

   logic stable_clk = 1'b0;
   logic prog_clk   = 1'b0;
   logic resetn     = 1'b0;
   logic clk_select = 1'b0;
   logic out_clk;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   int  rise_cnt = 0;
   int  short_hi = 0;
   int  glitch   = 0;
   int  both_en  = 0;
   time last_t   = 0;
   time max_lo   = 0;
   time last_hi  = 0;

   clk_stabilizer_gf #(
      .SYNC_STAGES(2),
      .DEAD_CYCLES(2)
   ) dut (
      .stable_clk (stable_clk),
      .resetn     (resetn),
      .clk_select (clk_select),
      .prog_clk   (prog_clk),
      .out_clk    (out_clk)
   );

   always #300 stable_clk = ~stable_clk;

   initial begin
      #50;
      forever #100 prog_clk = ~prog_clk;
   end

   always @(out_clk) begin
      if ($time > 0) begin
         if ($time - last_t < 100) glitch++;
         if (out_clk) begin
            rise_cnt++;
            if ($time - last_t > max_lo) max_lo = $time - last_t;
         end else begin
            last_hi = $time - last_t;
            if ($time - last_t < 200) short_hi++;
         end
      end
      last_t = $time;
   end

   always @(negedge stable_clk) begin
      if (dut.en_s_q && dut.en_p_q) both_en++;
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic measure(input string tag);
      int c0;
      int e;
      c0 = rise_cnt;
      #(WIN);
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 1, 0);
      end else begin
         e = exp_q.pop_front();
         chk(tag, rise_cnt - c0, e);
      end
   endtask

   task automatic align();
      @(posedge stable_clk);
      #1;
   endtask

   int sb;
   time t0;

   initial begin
      repeat (4) begin
         @(posedge stable_clk);
         #1;
         chk("rst_out", out_clk, 0);
      end
      resetn = 1'b1;
      @(posedge stable_clk); #1; chk("rel_p1", out_clk, 0);
      @(posedge stable_clk); #1; chk("rel_p2", out_clk, 0);
      @(posedge stable_clk); #1; chk("rel_p3", out_clk, 1);
      @(negedge stable_clk); #1; chk("rel_n3", out_clk, 0);
      repeat (2) begin
         @(posedge stable_clk); #1; chk("track_hi", out_clk, 1);
         @(negedge stable_clk); #1; chk("track_lo", out_clk, 0);
      end

      align();
      exp_q.push_back(N_STAB);
      measure("settle_stab");

      align();
      max_lo = 0;
      clk_select = 1'b1;
      exp_q.push_back(N_PROG);
      #3700;
      measure("to_prog");
      chk("to_prog_gap", int'(max_lo >= MIN_GAP), 1);
      chk("prog_hi", int'(last_hi), 100);

      align();
      max_lo = 0;
      clk_select = 1'b0;
      exp_q.push_back(N_STAB);
      #3700;
      measure("to_stab");
      chk("to_stab_gap", int'(max_lo >= MIN_GAP), 1);
      chk("stab_hi", int'(last_hi), 300);

      align();
      for (int i = 0; i < 50; i++) begin
         clk_select = ~clk_select;
         exp_q.push_back(clk_select ? N_PROG : N_STAB);
         #3700;
         measure("toggle");
         #200;
      end
      chk("toggle_end_sel", clk_select, 0);

      align();
      sb = short_hi;
      max_lo = 0;
      clk_select = 1'b1;
      #700;
      clk_select = 1'b0;
      exp_q.push_back(N_STAB);
      #3000;
      measure("revert");
      chk("revert_no_prog", short_hi - sb, 0);
      chk("revert_gap", int'(max_lo >= MIN_GAP), 1);

      align();
      clk_select = 1'b1;
      exp_q.push_back(N_PROG);
      #3700;
      measure("pre_rst");

      align();
      t0 = $time;
      resetn = 1'b0;
      @(posedge stable_clk);
      #400;
      chk("rst_prog_low", out_clk, 0);
      exp_q.push_back(N_IDLE);
      measure("rst_idle");
      chk("rst_prog_bound", int'($time - t0 < 3000), 1);

      align();
      resetn = 1'b1;
      exp_q.push_back(N_PROG);
      #3700;
      measure("rel_prog");

      chk("glitch", glitch, 0);
      chk("both_en", both_en, 0);
      chk("sb_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
